// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port data
//                RAM (registered address, one-cycle read latency). Supports
//                locked bursts of up to MAX_BURST consecutive grants.
//                Optional grant/conflict statistics when the macro
//                RAM_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_count0,
    output logic [15:0]       gnt_count1,
    output logic [15:0]       conflict_count
`endif
);

    localparam int                 CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   C_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } owner_t;

    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic             r_last_gnt;
    logic             w_last_gnt_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hold0;
    logic             w_hold1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             r_rvalid0;
    logic             r_rvalid1;

    // Arbitration state register: owner, round-robin pointer and burst count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= S_NONE;
            r_last_gnt  <= 1'b1;
            r_burst_cnt <= '0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Grant decision and next-state computation; ownership falls back to
    // NONE whenever no grant extends it, so a dropped owner request releases
    // the lock in the same cycle.
    always_comb begin
        w_gnt0          = 1'b0;
        w_gnt1          = 1'b0;
        w_owner_nxt     = S_NONE;
        w_last_gnt_nxt  = r_last_gnt;
        w_burst_cnt_nxt = '0;
        w_cnt_inc       = C_CNT_ONE;
        w_hold0         = (r_owner == S_OWN0) && req0;
        w_hold1         = (r_owner == S_OWN1) && req1;

        if (reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (w_hold0) begin
            w_gnt0 = 1'b1;
        end else if (w_hold1) begin
            w_gnt1 = 1'b1;
        end else if (req0 && req1) begin
            // Tie: the port that did not win last time goes first
            if (r_last_gnt) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else if (req0) begin
            w_gnt0 = 1'b1;
        end else if (req1) begin
            w_gnt1 = 1'b1;
        end

        // Continuing a locked burst extends the count, a fresh grant starts at 1
        if ((w_gnt0 && w_hold0) || (w_gnt1 && w_hold1)) begin
            w_cnt_inc = r_burst_cnt + C_CNT_ONE;
        end

        if (w_gnt0) begin
            w_last_gnt_nxt = 1'b0;
            if (lock0 && (w_cnt_inc < C_MAX_BURST)) begin
                w_owner_nxt     = S_OWN0;
                w_burst_cnt_nxt = w_cnt_inc;
            end
        end else if (w_gnt1) begin
            w_last_gnt_nxt = 1'b1;
            if (lock1 && (w_cnt_inc < C_MAX_BURST)) begin
                w_owner_nxt     = S_OWN1;
                w_burst_cnt_nxt = w_cnt_inc;
            end
        end
    end

    // RAM command mux: the winner of this cycle drives the RAM directly
    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        if (w_gnt0) begin
            ram_address = addr0;
            ram_data    = wdata0;
            ram_wren    = we0;
            ram_rden    = ~we0;
        end else if (w_gnt1) begin
            ram_address = addr1;
            ram_data    = wdata1;
            ram_wren    = we1;
            ram_rden    = ~we1;
        end
    end

    // Read-valid pipeline matching the RAM's one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rvalid0 ? ram_q : '0;
    assign rdata1  = r_rvalid1 ? ram_q : '0;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] r_gnt_count0;
    logic [15:0] r_gnt_count1;
    logic [15:0] r_conflict_count;
    logic        w_conflict;

    assign w_conflict = (req0 & ~w_gnt0) | (req1 & ~w_gnt1);

    // Saturating grant and denied-request counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_count0     <= '0;
            r_gnt_count1     <= '0;
            r_conflict_count <= '0;
        end else begin
            if (w_gnt0 && (r_gnt_count0 != 16'hFFFF)) begin
                r_gnt_count0 <= r_gnt_count0 + 16'd1;
            end
            if (w_gnt1 && (r_gnt_count1 != 16'hFFFF)) begin
                r_gnt_count1 <= r_gnt_count1 + 16'd1;
            end
            if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
                r_conflict_count <= r_conflict_count + 16'd1;
            end
        end
    end

    assign gnt_count0     = r_gnt_count0;
    assign gnt_count1     = r_gnt_count1;
    assign conflict_count = r_conflict_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed self-checking bench for ram_arbiter with a small
//                behavioural single-port RAM (registered address, 1-cycle read).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_rden, ram_wren;
    logic [DATA_W-1:0] ram_q;
`ifdef RAM_ARB_STATS_EN
    logic [15:0]       gnt_count0, gnt_count1, conflict_count;
`endif

    int n_checks;
    int n_pass;

    bit [DATA_W-1:0] mem [1024];

    ram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .lock0      (lock0),
        .lock1      (lock1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_rden   (ram_rden),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
`ifdef RAM_ARB_STATS_EN
        ,
        .gnt_count0    (gnt_count0),
        .gnt_count1    (gnt_count1),
        .conflict_count(conflict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write and registered read at the clock edge
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ram_q    = '0;
        idle_inputs();
        reset = 1'b1;

        // ---------------- Reset state with a pending request ----------------
        next_cycle();
        req0 = 1; addr0 = 10'd7; wdata0 = 32'hAAAA5555; we0 = 1;
        #1;
        chk("rst_gnt0",     {31'd0, gnt0}, 32'd0);
        chk("rst_wren",     {31'd0, ram_wren}, 32'd0);
        chk("rst_rden",     {31'd0, ram_rden}, 32'd0);
        chk("rst_addr",     {22'd0, ram_address}, 32'd0);
        chk("rst_data",     ram_data, 32'd0);
        chk("rst_rvalid0",  {31'd0, rvalid0}, 32'd0);
        idle_inputs();
        next_cycle();
        reset = 1'b0;

        // ---------------- Port 0 write then read ----------------
        next_cycle();
        req0 = 1; we0 = 1; addr0 = 10'd5; wdata0 = 32'hDEADBEEF;
        #1;
        chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
        chk("wr_wren", {31'd0, ram_wren}, 32'd1);
        chk("wr_addr", {22'd0, ram_address}, 32'd5);
        chk("wr_data", ram_data, 32'hDEADBEEF);
        next_cycle();
        we0 = 1; addr0 = 10'd6; wdata0 = 32'h12345678;
        #1;
        chk("wr2_gnt0", {31'd0, gnt0}, 32'd1);
        next_cycle();
        we0 = 0; addr0 = 10'd5;
        #1;
        chk("rd_gnt0",    {31'd0, gnt0}, 32'd1);
        chk("rd_rden",    {31'd0, ram_rden}, 32'd1);
        chk("rd_rvalid0_early", {31'd0, rvalid0}, 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        chk("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("rd_rdata0",  rdata0, 32'hDEADBEEF);
        chk("rd_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rd_rdata1",  rdata1, 32'd0);
        next_cycle();
        #1;
        chk("rd_rvalid0_drop", {31'd0, rvalid0}, 32'd0);

        // ---------------- Alternating reads, no lock ----------------
        do_reset();
        next_cycle();
        req0 = 1; req1 = 1; addr0 = 10'd5; addr1 = 10'd6;
        #1;
        chk("rr0_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        next_cycle();
        #1;
        chk("rr1_gnt",    {30'd0, gnt1, gnt0}, 32'b10);
        chk("rr1_rvalid", {30'd0, rvalid1, rvalid0}, 32'b01);
        chk("rr1_rdata0", rdata0, 32'hDEADBEEF);
        next_cycle();
        #1;
        chk("rr2_gnt",    {30'd0, gnt1, gnt0}, 32'b01);
        chk("rr2_rvalid", {30'd0, rvalid1, rvalid0}, 32'b10);
        chk("rr2_rdata1", rdata1, 32'h12345678);
        next_cycle();
        #1;
        chk("rr3_gnt",    {30'd0, gnt1, gnt0}, 32'b10);
        chk("rr3_rvalid", {30'd0, rvalid1, rvalid0}, 32'b01);
        next_cycle();
        idle_inputs();
        #1;
        chk("rr4_rvalid", {30'd0, rvalid1, rvalid0}, 32'b10);

        // ---------------- Locked burst on port 1 ----------------
        next_cycle();
        req1 = 1; lock1 = 1; addr1 = 10'd6;
        #1;
        chk("bu1_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            req0 = 1; addr0 = 10'd5;
            #1;
            chk($sformatf("bu%0d_gnt", i), {30'd0, gnt1, gnt0}, 32'b10);
        end
        next_cycle();
        #1;
        chk("bu5_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        next_cycle();
        #1;
        chk("bu6_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        next_cycle();
        idle_inputs();
        #1;
        chk("bu7_gnt",  {30'd0, gnt1, gnt0}, 32'b00);
        chk("bu7_rden", {30'd0, ram_wren, ram_rden}, 32'b00);

        // ---------------- Owner 0 drops request ----------------
        next_cycle();
        req0 = 1; lock0 = 1;
        #1;
        chk("own_gnt0", {30'd0, gnt1, gnt0}, 32'b01);
        next_cycle();
        req0 = 0; lock0 = 0; req1 = 1; addr1 = 10'd9;
        #1;
        chk("own_drop_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        chk("own_drop_addr", {22'd0, ram_address}, 32'd9);
        next_cycle();
        req0 = 1;
        #1;
        chk("own_none_tie", {30'd0, gnt1, gnt0}, 32'b01);
        next_cycle();
        idle_inputs();

        // ---------------- Reset during read return ----------------
        next_cycle();
        req0 = 1; addr0 = 10'd5;
        #1;
        chk("rr_gnt0", {31'd0, gnt0}, 32'd1);
        next_cycle();
        chk("rr_rvalid_pre", {31'd0, rvalid0}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_rvalid_rst", {31'd0, rvalid0}, 32'd0);
        chk("rr_gnt_rst",    {30'd0, gnt1, gnt0}, 32'b00);
        chk("rr_en_rst",     {30'd0, ram_wren, ram_rden}, 32'b00);
        next_cycle();
        chk("rr_rvalid_hold", {31'd0, rvalid0}, 32'd0);
        reset = 1'b0;
        req1 = 1; addr1 = 10'd6;
        #1;
        chk("rr_tie_after_rst", {30'd0, gnt1, gnt0}, 32'b01);
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            #1;
        end
        chk("rr_tie_10", {30'd0, gnt1, gnt0}, 32'b10);
        next_cycle();
        idle_inputs();
        #1;
`ifdef RAM_ARB_STATS_EN
        chk("st_gnt_sum", {16'd0, gnt_count0 + gnt_count1}, 32'd10);
        chk("st_conflict", {16'd0, conflict_count}, 32'd10);
`endif
        chk("end_rvalid1", {31'd0, rvalid1}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter that shares the single-port data RAM (32x1024, registered address, one-cycle read latency) between the CPU load/store path (port 0) and a secondary master such as a program loader or debug/DMA engine (port 1).
- Round-robin fairness with optional locked bursts, capped at MAX_BURST.
- Sits between the requesters and the RAM instance. Drives RAM address, data, rden and wren; returns read data and a valid strobe to the granted port.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive grants to a locked owner (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until gnt
- we0 / we1  in  1  1=write, 0=read (valid with req)
- lock0 / lock1  in  1  request to keep ownership for the next access
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational; access accepted this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata0 / rdata1  out  DATA_W  ram_q when matching rvalid, else 0
- ram_address  out  ADDR_W  to RAM
- ram_data  out  DATA_W  to RAM
- ram_rden  out  1  to RAM
- ram_wren  out  1  to RAM
- ram_q  in  DATA_W  from RAM

Behaviour:
- State: owner ∈ {NONE, OWN0, OWN1}; last_gnt (1 bit); burst_cnt (ceil(log2(MAX_BURST+1)) bits).
- Reset (asynchronous):
  - owner=NONE, last_gnt=1 (port 0 wins the first tie), burst_cnt=0.
  - rvalid0/1=0.
  - While reset is high, gnt0/1, ram_rden, ram_wren, ram_address and ram_data are all forced to 0.
- Arbitration in NONE, all combinational:
  - Only one req high: that port is granted.
  - Both req high: the port ≠ last_gnt is granted.
  - No req: no grant, RAM enables 0.
- Arbitration in OWNx:
  - req_x high: x is granted; the other port is blocked.
  - req_x low: ownership drops this cycle and NONE rules apply in the same cycle.
- At most one gnt per cycle. A grant in cycle N drives the RAM from the winner in cycle N: ram_address=addr, ram_data=wdata, ram_wren=we, ram_rden=~we.
- Update on a grant to x at the clock edge:
  - last_gnt ← x.
  - If lock_x=1 and the resulting burst count < MAX_BURST: owner ← OWNx, burst_cnt ← burst_cnt+1 (count starts at 1 on a fresh grant from NONE).
  - Otherwise: owner ← NONE, burst_cnt ← 0.
  - Consequence: the MAX_BURST-th consecutive locked grant always releases ownership, and the other port then wins the tie.
- Read latency: grant in cycle N gives rvalid_x=1 in cycle N+1 with rdata_x=ram_q. Back-to-back reads are permitted every cycle; rvalid stays high continuously.
- Writes complete at the edge that ends cycle N. No rvalid is generated for a write.
- Read issued the cycle after a write to the same address returns the new data (RAM write-then-read ordering).
- Reset asserted mid-operation: any in-flight rvalid is dropped (forced to 0) and the pending read is lost. The requester must re-issue it.
- Requester protocol violations (addr/we changing while waiting) are tolerated. Whatever is presented in the grant cycle is used.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, adds three output ports:
  - gnt_count0 [15:0]: saturating count of port-0 grants.
  - gnt_count1 [15:0]: saturating count of port-1 grants.
  - conflict_count [15:0]: saturating count of cycles where a request was denied.
  - All three clear to 0 on reset and saturate at 16'hFFFF.
- When undefined: the ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset release; port 0 only: write addr 5 = 0xDEADBEEF, then read addr 5 → gnt0 both cycles; rvalid0=1 exactly one cycle after the read grant with rdata0=0xDEADBEEF; rvalid1=0 throughout.
- Both ports request reads continuously, lock=0 → grants alternate 0,1,0,1 starting with port 0; each rvalid follows its grant by one cycle.
- MAX_BURST=4; port 1 holds req1, lock1=1 while port 0 also requests → exactly 4 consecutive gnt1, then gnt0. With lock0=0, the next grant returns to port 1.
- Port 0 locked (owner=OWN0) deasserts req0 while req1 is high → gnt1 in the same cycle; owner returns to NONE.
- Read granted in cycle N, reset pulsed during cycle N+1 → rvalid0=0 in that cycle; after reset, the first tie goes to port 0; all RAM enables are 0 while reset is high.
- With RAM_ARB_STATS_EN: 10 contested cycles → gnt_count0+gnt_count1=10 and conflict_count=10; counters saturate at 0xFFFF under a long run.
